// File: rtl/mux_rd_arbiter_pkg.sv
// Shared constants and FSM state type for the 16:1 read-mux sequencer/arbiter.
package mux_rd_arbiter_pkg;

    localparam int SEL_W = 4;
    localparam int N_IN  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past ptr, yields a one-hot grant and its index.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cidx;
        logic             found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        cidx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cidx = IDX_W'(cand);
            if (en && !found && req[cidx]) begin
                found       = 1'b1;
                grant[cidx] = 1'b1;
                idx         = cidx;
            end
        end
    end

endmodule

// File: rtl/mux_rd_arbiter.sv
// Shares an external 16:1 bit mux between NREQ requesters (round-robin, one grant per cycle)
// and provides a scan mode that walks all 16 selects into a snapshot word.
module mux_rd_arbiter
    import mux_rd_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [SEL_W*NREQ-1:0] req_addr,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       resp_valid,
    output logic                  resp_data,
    input  logic                  scan_start,
    output logic                  scan_busy,
    output logic                  scan_done,
    output logic [N_IN-1:0]       scan_word,
    output logic [SEL_W-1:0]      mux_sel,
    input  logic                  mux_out,
    output state_t                fsm_state
);

    localparam int IDX_W = $clog2(NREQ);

    state_t           state, state_nx;
    logic [IDX_W-1:0] last_grant, win_idx, s1_owner;
    logic             s1_valid;
    logic [SEL_W-1:0] cnt;
    logic [SEL_W-1:0] win_addr;
    logic [NREQ-1:0]  grant;
    logic             arb_en, hs;

    // Handshake: requester i transfers at an edge where req_valid[i] & req_ready[i];
    // the grant is forced off in reset, outside IDLE, and when a scan is being requested.
    assign arb_en = rst_n && (state == IDLE) && !scan_start;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (last_grant),
        .en    (arb_en),
        .grant (grant),
        .idx   (win_idx)
    );

    assign req_ready = grant;
    assign hs        = |(req_valid & grant);
    assign win_addr  = req_addr[int'(win_idx)*SEL_W +: SEL_W];
    assign scan_busy = (state == SCAN);
    assign scan_done = (state == DONE);
    assign fsm_state = state;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (scan_start) state_nx = SCAN;
            SCAN:    if (cnt == SEL_W'(N_IN - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mux_sel    <= '0;
            cnt        <= '0;
            s1_valid   <= 1'b0;
            s1_owner   <= '0;
            last_grant <= IDX_W'(NREQ - 1);
            resp_valid <= '0;
            resp_data  <= 1'b0;
            scan_word  <= '0;
        end else begin
            state      <= state_nx;
            s1_valid   <= hs;
            resp_valid <= '0;
            // Stage 2 samples the mux while mux_sel still holds the granted address.
            if (s1_valid) begin
                resp_valid <= NREQ'(1) << s1_owner;
                resp_data  <= mux_out;
            end
            if (hs) begin
                s1_owner   <= win_idx;
                last_grant <= win_idx;
                mux_sel    <= win_addr;
            end
            case (state)
                IDLE: begin
                    if (scan_start) begin
                        mux_sel <= '0;
                        cnt     <= '0;
                    end
                end
                SCAN: begin
                    scan_word[cnt] <= mux_out;
                    if (cnt != SEL_W'(N_IN - 1)) begin
                        mux_sel <= mux_sel + 1'b1;
                        cnt     <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
